// File: rtl/bayer_rx_monitor.sv
// ---------------------------------------------------------------------------
// bayer_rx_monitor
//
// Sink-side receiver for a GRBG Bayer video stream. It locks to the first
// frame start, then tags every valid pixel with its column, row and CFA
// colour phase for the demosaic stages. It also checks each line's pixel
// count and each frame's line count, and produces a per-frame modulo-2^32
// pixel checksum.
//
// Ports
//   clk          pixel clock
//   rst          synchronous, active-high reset
//   bayer_hsync  line sync (active low); monitored only, not used for counting
//   bayer_vsync  frame sync (active low); its falling edge is frame start
//   bayer_de     pixel valid; its falling edge is line end
//   bayer_data   raw Bayer pixel
//   pix_de       registered pixel valid (1-cycle latency)
//   pix_data     registered pixel
//   pix_x/pix_y  column/row index of pix_data
//   pix_color    colour phase {row[0], col[0]}: 0=Gr 1=R 2=B 3=Gb
//   frame_done   1-cycle pulse; frame_lines/frame_sum are updated on it
//   frame_lines  lines counted in the frame just closed
//   frame_sum    sum of bayer_data over the frame just closed
//   err_hlen     sticky: a line had a pixel count other than H_DISP
//   err_vlen     sticky: a frame had a line count other than V_DISP
//   locked       high once the first frame start has been seen
//
// Handshake: there is no backpressure. A pixel is transferred on every
// cycle where bayer_de is high; the tagged copy appears on the pix_* outputs
// exactly one cycle later, qualified by pix_de.
// ---------------------------------------------------------------------------
module bayer_rx_monitor #(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480,
    parameter int CW     = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bayer_hsync,
    input  logic          bayer_vsync,
    input  logic          bayer_de,
    input  logic [7:0]    bayer_data,
    output logic          pix_de,
    output logic [7:0]    pix_data,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [1:0]    pix_color,
    output logic          frame_done,
    output logic [CW-1:0] frame_lines,
    output logic [31:0]   frame_sum,
    output logic          err_hlen,
    output logic          err_vlen,
    output logic          locked
);

    localparam logic [CW-1:0] H_LEN = CW'(H_DISP);
    localparam logic [CW-1:0] V_LEN = CW'(V_DISP);
    localparam logic [CW-1:0] X_MAX = '1;

    typedef enum logic {
        S_HUNT  = 1'b0,
        S_FRAME = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Edge-detection history
    logic r_vsync_d;
    logic r_de_d;

    // Running counters for the open frame
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [CW-1:0] r_lines;
    logic [31:0]   r_sum;

    // Output registers
    logic          r_pix_de;
    logic [7:0]    r_pix_data;
    logic [CW-1:0] r_pix_x;
    logic [CW-1:0] r_pix_y;
    logic [1:0]    r_pix_color;
    logic          r_frame_done;
    logic [CW-1:0] r_frame_lines;
    logic [31:0]   r_frame_sum;
    logic          r_err_hlen;
    logic          r_err_vlen;

    logic          w_fs;
    logic          w_le;
    logic          w_locked;
    logic [CW-1:0] w_lines_le;
    logic [CW-1:0] w_x_base;
    logic [CW-1:0] w_y_base;
    logic [CW-1:0] w_lines_base;
    logic [31:0]   w_sum_base;
    logic [CW-1:0] w_x_inc;

    // hsync is observed but deliberately plays no part in counting.
    logic w_unused_hsync;
    assign w_unused_hsync = bayer_hsync;

    assign w_fs = r_vsync_d & ~bayer_vsync;
    assign w_le = r_de_d & ~bayer_de;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HUNT:  if (w_fs) w_state_nxt = S_FRAME;
            S_FRAME: w_state_nxt = S_FRAME;
            default: w_state_nxt = S_HUNT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_locked = 1'b0;
        if (r_state == S_FRAME) w_locked = 1'b1;
    end

    // Counter values as seen by this cycle's pixel. A line end is applied
    // before a coincident frame start, so the closing frame still counts
    // its last line; the frame start then zeroes everything so a pixel on
    // the same cycle lands at (0,0) of the new frame.
    always_comb begin
        w_lines_le = r_lines;
        if (w_le) w_lines_le = r_lines + 1'b1;

        w_x_base     = r_x;
        w_y_base     = r_y;
        w_lines_base = w_lines_le;
        w_sum_base   = r_sum;
        if (w_le) begin
            w_x_base = '0;
            w_y_base = r_y + 1'b1;
        end
        if (w_fs) begin
            w_x_base     = '0;
            w_y_base     = '0;
            w_lines_base = '0;
            w_sum_base   = '0;
        end

        // x saturates rather than wrapping on an over-long line
        w_x_inc = (w_x_base == X_MAX) ? X_MAX : w_x_base + 1'b1;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_d     <= 1'b0;
            r_de_d        <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_lines       <= '0;
            r_sum         <= '0;
            r_pix_de      <= 1'b0;
            r_pix_data    <= '0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_color   <= '0;
            r_frame_done  <= 1'b0;
            r_frame_lines <= '0;
            r_frame_sum   <= '0;
            r_err_hlen    <= 1'b0;
            r_err_vlen    <= 1'b0;
        end else begin
            r_vsync_d    <= bayer_vsync;
            r_de_d       <= bayer_de;
            r_frame_done <= 1'b0;
            r_pix_de     <= 1'b0;

            if (r_state == S_HUNT) begin
                // Pixels and checks are ignored until the first frame start
                if (w_fs) begin
                    r_x     <= '0;
                    r_y     <= '0;
                    r_lines <= '0;
                    r_sum   <= '0;
                end
            end else begin
                if (w_le && (r_x != H_LEN)) r_err_hlen <= 1'b1;

                if (w_fs) begin
                    r_frame_done  <= 1'b1;
                    r_frame_lines <= w_lines_le;
                    r_frame_sum   <= r_sum;
                    if (w_lines_le != V_LEN) r_err_vlen <= 1'b1;
                end

                r_x     <= w_x_base;
                r_y     <= w_y_base;
                r_lines <= w_lines_base;
                r_sum   <= w_sum_base;

                if (bayer_de) begin
                    r_pix_de    <= 1'b1;
                    r_pix_data  <= bayer_data;
                    r_pix_x     <= w_x_base;
                    r_pix_y     <= w_y_base;
                    r_pix_color <= {w_y_base[0], w_x_base[0]};
                    r_x         <= w_x_inc;
                    r_sum       <= w_sum_base + {24'd0, bayer_data};
                end
            end
        end
    end

    assign pix_de      = r_pix_de;
    assign pix_data    = r_pix_data;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_color   = r_pix_color;
    assign frame_done  = r_frame_done;
    assign frame_lines = r_frame_lines;
    assign frame_sum   = r_frame_sum;
    assign err_hlen    = r_err_hlen;
    assign err_vlen    = r_err_vlen;
    assign locked      = w_locked;

endmodule

// File: tb/tb_bayer_rx_monitor.sv
module tb_bayer_rx_monitor;

    localparam int H_DISP = 8;
    localparam int V_DISP = 4;
    localparam int CW     = 11;
    localparam int X_MAX  = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          bayer_hsync = 1'b1;
    logic          bayer_vsync = 1'b1;
    logic          bayer_de    = 1'b0;
    logic [7:0]    bayer_data  = 8'd0;
    logic          pix_de;
    logic [7:0]    pix_data;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic [1:0]    pix_color;
    logic          frame_done;
    logic [CW-1:0] frame_lines;
    logic [31:0]   frame_sum;
    logic          err_hlen;
    logic          err_vlen;
    logic          locked;

    bayer_rx_monitor #(.H_DISP(H_DISP), .V_DISP(V_DISP), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bayer_hsync (bayer_hsync),
        .bayer_vsync (bayer_vsync),
        .bayer_de    (bayer_de),
        .bayer_data  (bayer_data),
        .pix_de      (pix_de),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .frame_done  (frame_done),
        .frame_lines (frame_lines),
        .frame_sum   (frame_sum),
        .err_hlen    (err_hlen),
        .err_vlen    (err_vlen),
        .locked      (locked)
    );

    // ---------------- scoreboard ----------------
    // pixel entry: {data[7:0], x[10:0], y[10:0], color[1:0]}
    logic [31:0] exp_q[$];
    // frame entry: {lines[10:0], sum[31:0]}
    logic [42:0] frm_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of the receiver, stepped once per driven cycle
    bit          m_locked = 1'b0;
    bit          m_pvs    = 1'b0;
    bit          m_pde    = 1'b0;
    int          m_x      = 0;
    int          m_y      = 0;
    int          m_lines  = 0;
    logic [31:0] m_sum    = '0;
    bit          e_hlen   = 1'b0;
    bit          e_vlen   = 1'b0;

    // ---------------- driver tasks ----------------
    task automatic drive(input bit vs, input bit hs, input bit de, input logic [7:0] d);
        bit fs;
        bit le;
        bit was;
        logic [CW-1:0] xs;
        logic [CW-1:0] ys;
        fs  = m_pvs && !vs;
        le  = m_pde && !de;
        was = m_locked;
        if (was && le) begin
            if (m_x != H_DISP) e_hlen = 1'b1;
            m_x = 0;
            m_y++;
            m_lines++;
        end
        if (fs) begin
            if (was) begin
                frm_q.push_back({m_lines[10:0], m_sum});
                if (m_lines != V_DISP) e_vlen = 1'b1;
            end
            m_locked = 1'b1;
            m_x      = 0;
            m_y      = 0;
            m_lines  = 0;
            m_sum    = '0;
        end
        if (was && de) begin
            xs = m_x[CW-1:0];
            ys = m_y[CW-1:0];
            exp_q.push_back({d, xs, ys, ys[0], xs[0]});
            if (m_x != X_MAX) m_x++;
            m_sum = m_sum + {24'd0, d};
        end
        m_pvs = vs;
        m_pde = de;
        bayer_vsync = vs;
        bayer_hsync = hs;
        bayer_de    = de;
        bayer_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int ncyc);
        rst         = 1'b1;
        bayer_vsync = 1'b1;
        bayer_hsync = 1'b1;
        bayer_de    = 1'b0;
        bayer_data  = 8'd0;
        repeat (ncyc) @(posedge clk);
        #1;
        m_locked = 1'b0;
        m_pvs    = 1'b0;
        m_pde    = 1'b0;
        m_x      = 0;
        m_y      = 0;
        m_lines  = 0;
        m_sum    = '0;
        e_hlen   = 1'b0;
        e_vlen   = 1'b0;
        check("rst_pix",   {pix_de, pix_data, pix_x, pix_y, pix_color}, 64'd0);
        check("rst_frame", {frame_done, frame_lines, frame_sum}, 64'd0);
        check("rst_flags", {err_hlen, err_vlen, locked}, 64'd0);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b0, 8'd0);
    endtask

    // One generator frame. short_line gets short_len pixels instead of
    // H_DISP; fs_pix puts pixel (0,0) on the vsync falling-edge cycle;
    // tail=0 leaves no gap after the last pixel, so the next frame start
    // coincides with that line's end.
    task automatic frame(input int nlines, input int short_line, input int short_len,
                         input bit fs_pix, input bit tail);
        int idx;
        int len;
        int start;
        idx = 0;
        drive(1'b0, 1'b1, fs_pix, 8'd0);
        if (fs_pix) idx = 1;
        else begin
            drive(1'b0, 1'b1, 1'b0, 8'd0);
            drive(1'b1, 1'b1, 1'b0, 8'd0);
        end
        for (int l = 0; l < nlines; l++) begin
            len   = (l == short_line) ? short_len : H_DISP;
            start = (l == 0 && fs_pix) ? 1 : 0;
            if (start == 0) begin
                drive(1'b1, 1'b0, 1'b0, 8'd0);
                drive(1'b1, 1'b1, 1'b0, 8'd0);
            end
            for (int i = start; i < len; i++) begin
                drive(1'b1, 1'b1, 1'b1, idx[7:0]);
                idx++;
            end
            if (l < nlines - 1 || tail) drive(1'b1, 1'b1, 1'b0, 8'd0);
        end
        if (tail) drive(1'b1, 1'b1, 1'b0, 8'd0);
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        logic [31:0] pe;
        logic [42:0] fe;
        if (pix_de) begin
            if (exp_q.size() == 0) check("pix_de_unexpected", {63'd0, pix_de}, 64'd0);
            else begin
                pe = exp_q.pop_front();
                check("pix", {32'd0, pix_data, pix_x, pix_y, pix_color}, {32'd0, pe});
            end
        end
        if (frame_done) begin
            if (frm_q.size() == 0) check("frame_done_unexpected", {63'd0, frame_done}, 64'd0);
            else begin
                fe = frm_q.pop_front();
                check("frame_stats", {21'd0, frame_lines, frame_sum}, {21'd0, fe});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        do_reset(3);
        idle(3);

        // de activity before any frame start is ignored
        for (int k = 0; k < 7; k++) drive(1'b1, 1'b1, 1'b1, 8'(k + 100));
        idle(2);
        check("prelock_locked", {63'd0, locked}, 64'd0);
        check("prelock_flags", {62'd0, err_hlen, err_vlen}, 64'd0);

        // three good frames, data = running index 0..31
        frame(4, -1, 0, 1'b0, 1'b1);
        check("lock_after_fs", {63'd0, locked}, 64'd1);
        frame(4, -1, 0, 1'b0, 1'b1);
        check("first_frame_lines", {53'd0, frame_lines}, 64'd4);
        check("first_frame_sum", {32'd0, frame_sum}, 64'd496);
        frame(4, -1, 0, 1'b0, 1'b1);
        check("good_flags", {62'd0, err_hlen, err_vlen}, 64'd0);

        // one 7-pixel line
        frame(4, 1, 7, 1'b0, 1'b1);
        check("short_hlen", {63'd0, err_hlen}, 64'd1);
        check("short_vlen", {63'd0, err_vlen}, 64'd0);
        frame(4, -1, 0, 1'b0, 1'b1);
        check("short_frame_sum", {32'd0, frame_sum}, 64'd465);
        check("hlen_sticky", {63'd0, err_hlen}, 64'd1);

        // three-line frame, closed by the next frame start
        frame(3, -1, 0, 1'b0, 1'b1);
        frame(4, -1, 0, 1'b0, 1'b1);
        check("three_line_lines", {53'd0, frame_lines}, 64'd3);
        check("three_line_vlen", {63'd0, err_vlen}, 64'd1);

        // pixel on the fs cycle; last line end coincides with the next fs
        frame(4, -1, 0, 1'b1, 1'b0);
        frame(4, -1, 0, 1'b0, 1'b1);
        check("fs_pix_lines", {53'd0, frame_lines}, 64'd4);
        check("fs_pix_sum", {32'd0, frame_sum}, 64'd496);

        // empty frame
        frame(0, -1, 0, 1'b0, 1'b1);
        frame(4, -1, 0, 1'b0, 1'b1);
        check("empty_lines", {53'd0, frame_lines}, 64'd0);
        check("empty_sum", {32'd0, frame_sum}, 64'd0);

        // over-long line: x saturates at 2^CW-1
        frame(4, 0, X_MAX + 3, 1'b0, 1'b1);

        // reset in the middle of a frame
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        drive(1'b1, 1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 1'b1, 8'(k + 7));
        do_reset(1);
        idle(3);
        frame(4, -1, 0, 1'b0, 1'b1);
        check("post_rst_no_done", {53'd0, frame_lines}, 64'd0);
        frame(4, -1, 0, 1'b0, 1'b1);
        check("post_rst_lines", {53'd0, frame_lines}, 64'd4);
        check("post_rst_sum", {32'd0, frame_sum}, 64'd496);
        check("post_rst_flags", {62'd0, err_hlen, err_vlen}, 64'd0);

        // model-tracked flags and drained queues
        check("flags_model", {62'd0, err_hlen, err_vlen}, {62'd0, e_hlen, e_vlen});
        idle(4);
        check("pix_q_drained", 64'(exp_q.size()), 64'd0);
        check("frm_q_drained", 64'(frm_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
